// File: rtl/bin2gray_counter.sv
// Up/down binary counter with a registered Gray-code view, step/wrap/saturation
// flags and a sticky monitor that flags any step whose Gray code moved by != 1 bit.
module bin2gray_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             stepped,
  output logic             wrap,
  output logic             sat,
  output logic             chg_err
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when a step in the given direction would leave the code range.
  function automatic logic at_end(input logic [WIDTH-1:0] b, input logic dir_up);
    return dir_up ? (b == MAX) : (b == '0);
  endfunction

  function automatic logic single_bit(input logic [WIDTH-1:0] d);
    return (d != '0) && ((d & (d - ONE)) == '0);
  endfunction

  logic [WIDTH-1:0] bin_p0, gray_p0;
  logic             stepped_p0, wrap_p0, sat_p0;
  logic [WIDTH-1:0] bin_p1, gray_p1;
  logic             stepped_p1, wrap_p1, sat_p1, chg_err_p1;

  // Stage p0: next-state selection (load > en > hold) and Gray encode.
  always_comb begin
    bin_p0     = bin_p1;
    stepped_p0 = 1'b0;
    wrap_p0    = 1'b0;
    sat_p0     = sat_p1;
    if (load) begin
      bin_p0 = load_bin;
      sat_p0 = 1'b0;
    end else if (en) begin
      if (SATURATE && at_end(bin_p1, up)) begin
        sat_p0 = 1'b1;
      end else begin
        bin_p0     = up ? (bin_p1 + ONE) : (bin_p1 - ONE);
        stepped_p0 = 1'b1;
        wrap_p0    = at_end(bin_p1, up);
        sat_p0     = 1'b0;
      end
    end
    gray_p0 = to_gray(bin_p0);
  end

  // Stage p1: output registers; the monitor compares old and new Gray on steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_p1     <= '0;
      gray_p1    <= '0;
      stepped_p1 <= 1'b0;
      wrap_p1    <= 1'b0;
      sat_p1     <= 1'b0;
      chg_err_p1 <= 1'b0;
    end else begin
      bin_p1     <= bin_p0;
      gray_p1    <= gray_p0;
      stepped_p1 <= stepped_p0;
      wrap_p1    <= wrap_p0;
      sat_p1     <= sat_p0;
      if (stepped_p0 && !single_bit(gray_p1 ^ gray_p0))
        chg_err_p1 <= 1'b1;
    end
  end

  assign bin_out  = bin_p1;
  assign gray_out = gray_p1;
  assign stepped  = stepped_p1;
  assign wrap     = wrap_p1;
  assign sat      = sat_p1;
  assign chg_err  = chg_err_p1;

endmodule

// File: tb/tb_bin2gray_counter.sv
// Directed vector table plus random reference-model run for bin2gray_counter,
// covering a wrapping instance and a saturating instance side by side.
module tb_bin2gray_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [3:0] load_bin;

  logic [3:0] w_bin, w_gray, s_bin, s_gray;
  logic       w_stepped, w_wrap, w_sat, w_chg_err;
  logic       s_stepped, s_wrap, s_sat, s_chg_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin2gray_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(w_bin), .gray_out(w_gray), .stepped(w_stepped), .wrap(w_wrap),
    .sat(w_sat), .chg_err(w_chg_err)
  );

  bin2gray_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .bin_out(s_bin), .gray_out(s_gray), .stepped(s_stepped), .wrap(s_wrap),
    .sat(s_sat), .chg_err(s_chg_err)
  );

  typedef struct {
    logic       rst, ld, en, up;
    logic [3:0] lb;
    logic       sel;   // 0: check wrapping instance, 1: saturating instance
    logic [3:0] eb, eg;
    logic       es, ew, esat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, ld, e, u, input logic [3:0] lb, input logic sel,
                     input logic [3:0] eb, eg, input logic es, ew, esat);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = e; v.up = u; v.lb = lb; v.sel = sel;
    v.eb = eb; v.eg = eg; v.es = es; v.ew = ew; v.esat = esat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ld, e, u, input logic [3:0] lb);
    reset = rst; load = ld; en = e; up = u; load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [3:0] gseq[16];
  logic [3:0] mw_b, ms_b;
  logic       mw_s, mw_w, ms_s, ms_w, ms_sat;
  logic       r_rst, r_ld, r_en, r_up;
  logic [3:0] r_lb;

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; load_bin = 4'h0;
    gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Wrapping instance: full up count, then loads, direction changes and reset.
    add(1, 0, 1, 1, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0);
    for (int i = 1; i <= 16; i++)
      add(0, 0, 1, 1, 4'h0, 0, 4'(i), gseq[i-1], 1, (i == 16), 0);
    add(0, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 4'h0, 0, 4'hF, 4'h8, 1, 1, 0);
    add(0, 1, 1, 1, 4'h5, 0, 4'h5, 4'h7, 0, 0, 0);
    add(0, 0, 1, 1, 4'h0, 0, 4'h6, 4'h5, 1, 0, 0);
    add(0, 0, 0, 1, 4'h0, 0, 4'h6, 4'h5, 0, 0, 0);
    add(0, 0, 1, 0, 4'h0, 0, 4'h5, 4'h7, 1, 0, 0);
    add(0, 1, 0, 1, 4'h7, 0, 4'h7, 4'h4, 0, 0, 0);
    add(0, 0, 1, 1, 4'h0, 0, 4'h8, 4'hC, 1, 0, 0);
    add(0, 0, 1, 1, 4'h0, 0, 4'h9, 4'hD, 1, 0, 0);
    add(1, 1, 1, 1, 4'h6, 0, 4'h0, 4'h0, 0, 0, 0);
    add(0, 0, 1, 1, 4'h0, 0, 4'h1, 4'h1, 1, 0, 0);
    add(0, 0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 1, 0, 0);
    add(0, 0, 1, 0, 4'h0, 0, 4'hF, 4'h8, 1, 1, 0);
    // Saturating instance: blocked steps at both ends, sat level behaviour.
    add(1, 0, 0, 1, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0);
    add(0, 1, 0, 1, 4'hF, 1, 4'hF, 4'h8, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 1, 1, 4'h0, 1, 4'hF, 4'h8, 0, 0, 1);
    add(0, 0, 1, 0, 4'h0, 1, 4'hE, 4'h9, 1, 0, 0);
    add(0, 1, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 1);
    add(0, 0, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 1);
    add(0, 0, 1, 1, 4'h0, 1, 4'h1, 4'h1, 1, 0, 0);
    add(0, 0, 1, 0, 4'h0, 1, 4'h0, 4'h0, 1, 0, 0);
    add(0, 0, 1, 0, 4'h0, 1, 4'h0, 4'h0, 0, 0, 1);
    add(0, 1, 1, 0, 4'h2, 1, 4'h2, 4'h3, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lb);
      if (vecs[i].sel == 1'b0) begin
        chk("wrap_bin",     i, 32'(w_bin),     32'(vecs[i].eb));
        chk("wrap_gray",    i, 32'(w_gray),    32'(vecs[i].eg));
        chk("wrap_stepped", i, 32'(w_stepped), 32'(vecs[i].es));
        chk("wrap_wrap",    i, 32'(w_wrap),    32'(vecs[i].ew));
        chk("wrap_sat",     i, 32'(w_sat),     32'(vecs[i].esat));
        chk("wrap_chg_err", i, 32'(w_chg_err), 32'(1'b0));
      end else begin
        chk("sat_bin",      i, 32'(s_bin),     32'(vecs[i].eb));
        chk("sat_gray",     i, 32'(s_gray),    32'(vecs[i].eg));
        chk("sat_stepped",  i, 32'(s_stepped), 32'(vecs[i].es));
        chk("sat_wrap",     i, 32'(s_wrap),    32'(vecs[i].ew));
        chk("sat_sat",      i, 32'(s_sat),     32'(vecs[i].esat));
        chk("sat_chg_err",  i, 32'(s_chg_err), 32'(1'b0));
      end
    end

    // Random run against an independent reference model of both variants.
    mw_b = 0; mw_s = 0; mw_w = 0; ms_b = 0; ms_s = 0; ms_w = 0; ms_sat = 0;
    for (int k = 0; k < 10000; k++) begin
      r_rst = (k == 0) || ($urandom_range(63) == 0);
      r_ld  = ($urandom_range(7) == 0);
      r_en  = ($urandom_range(3) != 0);
      r_up  = 1'($urandom_range(1));
      r_lb  = 4'($urandom_range(15));
      if (r_rst) begin
        mw_b = 0; mw_s = 0; mw_w = 0; ms_b = 0; ms_s = 0; ms_w = 0; ms_sat = 0;
      end else if (r_ld) begin
        mw_b = r_lb; mw_s = 0; mw_w = 0; ms_b = r_lb; ms_s = 0; ms_w = 0; ms_sat = 0;
      end else if (r_en) begin
        mw_w = r_up ? (mw_b == 4'hF) : (mw_b == 4'h0);
        mw_b = r_up ? mw_b + 4'd1 : mw_b - 4'd1;
        mw_s = 1;
        if (r_up ? (ms_b == 4'hF) : (ms_b == 4'h0)) begin
          ms_sat = 1; ms_s = 0; ms_w = 0;
        end else begin
          ms_b = r_up ? ms_b + 4'd1 : ms_b - 4'd1;
          ms_sat = 0; ms_s = 1; ms_w = 0;
        end
      end else begin
        mw_s = 0; mw_w = 0; ms_s = 0; ms_w = 0;
      end
      drive(r_rst, r_ld, r_en, r_up, r_lb);
      chk("rnd_wrap", k, 32'({w_bin, w_gray, w_stepped, w_wrap, w_sat, w_chg_err}),
          32'({mw_b, mw_b ^ (mw_b >> 1), mw_s, mw_w, 1'b0, 1'b0}));
      chk("rnd_sat",  k, 32'({s_bin, s_gray, s_stepped, s_wrap, s_sat, s_chg_err}),
          32'({ms_b, ms_b ^ (ms_b >> 1), ms_s, ms_w, ms_sat, 1'b0}));
      chk("rnd_wrap_g2b", k, 32'(g2b(w_gray)), 32'(mw_b));
      chk("rnd_sat_g2b",  k, 32'(g2b(s_gray)), 32'(ms_b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
